dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 7 +
 rtl/dmem_ctrl_amux.sv | 13 +
 rtl/dmem_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared defaults, FSM state encoding and owner encoding for dmem_ctrl
package dmem_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {IDLE, ACC, RD, DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;
endpackage

// File: rtl/dmem_ctrl_amux.sv
// dmem_ctrl_amux: CPU data-address mux, literal (sd=0) or register B (sd=1)
module dmem_ctrl_amux
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] lit,
  input  logic [AW-1:0] regb,
  input  logic          sd,
  output logic [AW-1:0] addr
);
  assign addr = sd ? regb : lit;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: round-robin CPU/debug data-memory controller; debug requester enabled by DMEM_CTRL_DBG_EN
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_lit,
  input  logic [AW-1:0] cpu_regb,
  input  logic          cpu_sd,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ready,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
`ifdef DMEM_CTRL_DBG_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif
  state_t        state;
  owner_t        owner;
  logic          we_q;
  logic          dbg_rdy;
  logic [DW-1:0] dbg_rd;
  logic [AW-1:0] cpu_addr;
  logic          dbg_go;
  logic          pick_dbg;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  dmem_ctrl_amux #(.AW(AW)) u_amux (
    .lit (cpu_lit),
    .regb(cpu_regb),
    .sd  (cpu_sd),
    .addr(cpu_addr)
  );
  // grant selection: debug wins only when the CPU is idle or was served last
  always_comb begin
    dbg_go = DBG_EN && dbg_req;
    pick_dbg = dbg_go && (!cpu_req || owner == OWN_CPU);
    g_we = pick_dbg ? dbg_we : cpu_we;
    g_addr = pick_dbg ? dbg_addr : cpu_addr;
    g_wdata = pick_dbg ? dbg_wdata : cpu_wdata;
  end
  // debug outputs are tied off when the debug requester is compiled out
  assign dbg_ready = DBG_EN && dbg_rdy;
  assign dbg_rdata = DBG_EN ? dbg_rd : '0;
  // transaction FSM; owner doubles as the last-served record for arbitration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= OWN_DBG;
      we_q <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      cpu_ready <= 1'b0;
      dbg_rdy <= 1'b0;
      cpu_rdata <= '0;
      dbg_rd <= '0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      cpu_ready <= 1'b0;
      dbg_rdy <= 1'b0;
      case (state)
        IDLE: if (cpu_req || dbg_go) begin
          owner <= pick_dbg ? OWN_DBG : OWN_CPU;
          we_q <= g_we;
          mem_addr <= g_addr;
          mem_wdata <= g_wdata;
          mem_we <= g_we;
          mem_re <= !g_we;
          state <= ACC;
        end
        ACC: begin
          cpu_ready <= we_q && owner == OWN_CPU;
          dbg_rdy <= we_q && owner == OWN_DBG;
          state <= we_q ? DONE : RD;
        end
        RD: begin
          if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
          else dbg_rd <= mem_rdata;
          cpu_ready <= owner == OWN_CPU;
          dbg_rdy <= owner == OWN_DBG;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
